// File: rtl/l1ci_pkg.sv
// l1ci_pkg: shared types and width helpers for the parametrised L1 instruction cache.
// Used by l1ci_way and l1c_inst_param (optional counters: L1CI_PERF_CNT_EN).
`timescale 1ns/1ps
package l1ci_pkg;

    // Controller states: wait for a fetch, compare tags, refill a line
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2
    } state_e;

    // Memory access type for a 32-bit word
    localparam logic [2:0] CACHE_WORD = 3'b010;

    // Byte-offset bits within a line (word select plus the two byte bits)
    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    // Set index bits
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Remaining upper address bits form the tag
    function automatic int tag_bits(input int sets, input int line_words);
        return 32 - idx_bits(sets) - off_bits(line_words);
    endfunction

endpackage

// File: rtl/l1ci_way.sv
// l1ci_way: tag, valid and data storage for one cache way.
// Flop arrays read combinationally at the latched index; writes land on the next edge.
`timescale 1ns/1ps
module l1ci_way
    import l1ci_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [idx_bits(SETS)-1:0]           idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0]       rd_word_i,
    input  logic                                data_we_i,
    input  logic [$clog2(LINE_WORDS)-1:0]       wr_word_i,
    input  logic [31:0]                         wr_data_i,
    input  logic                                tag_we_i,
    input  logic [tag_bits(SETS,LINE_WORDS)-1:0] tag_i,
    input  logic                                inval_i,
    input  logic                                clr_all_i,
    output logic                                valid_o,
    output logic [tag_bits(SETS,LINE_WORDS)-1:0] tag_o,
    output logic [31:0]                         data_o
);

    localparam int TAG_BITS = tag_bits(SETS, LINE_WORDS);

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [31:0]         data_q [SETS][LINE_WORDS];

    // Valid bits: cleared on reset/flush, dropped when a refill begins, set when it completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[idx_i] <= 1'b1;
        end else if (inval_i) begin
            valid_q[idx_i] <= 1'b0;
        end
    end

    // Tag storage, written together with the final fill beat
    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[idx_i] <= tag_i;
        end
    end

    // Line data, one word per completed fill beat
    always_ff @(posedge clk) begin
        if (data_we_i) begin
            data_q[idx_i][wr_word_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i][rd_word_i];

endmodule

// File: rtl/l1c_inst_param.sv
// l1c_inst_param: read-only L1 instruction cache, 1 or 2 ways with per-set LRU.
// Define L1CI_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
`timescale 1ns/1ps
module l1c_inst_param
    import l1ci_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    input  logic        core_req,
    input  logic        core_write,
    input  logic [31:0] core_in,
    input  logic [2:0]  core_type,
    input  logic        flush,
    input  logic [31:0] I_out,
    input  logic        I_wait,
    output logic [31:0] core_out,
    output logic        core_wait,
    output logic        I_req,
    output logic [31:0] I_addr,
    output logic        I_write,
    output logic [31:0] I_in,
    output logic [2:0]  I_type
`ifdef L1CI_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_BITS  = off_bits(LINE_WORDS);
    localparam int IDX_BITS  = idx_bits(SETS);
    localparam int TAG_BITS  = tag_bits(SETS, LINE_WORDS);
    localparam int WSEL_BITS = $clog2(LINE_WORDS);
    localparam logic [WSEL_BITS-1:0] LAST_WORD = WSEL_BITS'(LINE_WORDS - 1);

    state_e               state_q, state_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [TAG_BITS-1:0]  tag_q, tag_d;
    logic [WSEL_BITS-1:0] woff_q, woff_d;
    logic [WSEL_BITS-1:0] cnt_q, cnt_d;
    logic                 victim_q, victim_d;
    logic                 flush_pend_q, flush_pend_d;

    logic                 valid_w [WAYS];
    logic [TAG_BITS-1:0]  tag_w   [WAYS];
    logic [31:0]          data_w  [WAYS];
    logic [WAYS-1:0]      hit_w;

    logic                 hit, hit_way, victim_sel, lru_rd;
    logic [31:0]          hit_data;
    logic                 flush_now, accept, miss_start, beat_done, last_beat;

    // Inputs of a read-only word-fetch port that carry no information here
    logic unused_ok;
    assign unused_ok = ^{core_write, core_in, core_type, core_addr[1:0]};

    // A pending or fresh flush is applied only in IDLE, ahead of any request
    assign flush_now  = (state_q == ST_IDLE) && (flush || flush_pend_q);
    assign accept     = (state_q == ST_IDLE) && !(flush || flush_pend_q) && core_req;
    assign miss_start = (state_q == ST_LOOKUP) && !hit;
    assign beat_done  = (state_q == ST_FILL) && !I_wait;
    assign last_beat  = beat_done && (cnt_q == LAST_WORD);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            l1ci_way #(
                .SETS       (SETS),
                .LINE_WORDS (LINE_WORDS)
            ) u_way (
                .clk       (clk),
                .rst       (rst),
                .idx_i     (idx_q),
                .rd_word_i (woff_q),
                .data_we_i (beat_done && (victim_q == 1'(gi))),
                .wr_word_i (cnt_q),
                .wr_data_i (I_out),
                .tag_we_i  (last_beat && (victim_q == 1'(gi))),
                .tag_i     (tag_q),
                .inval_i   (miss_start && (victim_sel == 1'(gi))),
                .clr_all_i (flush_now),
                .valid_o   (valid_w[gi]),
                .tag_o     (tag_w[gi]),
                .data_o    (data_w[gi])
            );
            assign hit_w[gi] = valid_w[gi] && (tag_w[gi] == tag_q);
        end

        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] lru_q;
            // LRU bit names the way to evict next: the one not just used or filled
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lru_q <= '0;
                end else if (flush_now) begin
                    lru_q <= '0;
                end else if ((state_q == ST_LOOKUP) && hit) begin
                    lru_q[idx_q] <= ~hit_way;
                end else if (last_beat) begin
                    lru_q[idx_q] <= ~victim_q;
                end
            end
            assign lru_rd = lru_q[idx_q];
        end else begin : g_no_lru
            assign lru_rd = 1'b0;
        end
    endgenerate

    // Tag compare across the ways and selection of the hitting word
    always_comb begin
        hit      = 1'b0;
        hit_way  = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_w[w]) begin
                hit      = 1'b1;
                hit_way  = 1'(w);
                hit_data = data_w[w];
            end
        end
    end

    // Victim choice: an empty way first, otherwise the LRU way
    always_comb begin
        victim_sel = 1'b0;
        if (WAYS == 2) begin
            if (!valid_w[0]) begin
                victim_sel = 1'b0;
            end else if (!valid_w[WAYS-1]) begin
                victim_sel = 1'b1;
            end else begin
                victim_sel = lru_rd;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a completed fill returns to LOOKUP which then hits
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)    state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = hit ? ST_IDLE : ST_FILL;
            ST_FILL:   if (last_beat) state_d = ST_LOOKUP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: data only in the hit cycle, fill request only in FILL
    always_comb begin
        core_wait = 1'b1;
        core_out  = '0;
        I_req     = 1'b0;
        I_addr    = '0;
        if ((state_q == ST_LOOKUP) && hit) begin
            core_wait = 1'b0;
            core_out  = hit_data;
        end
        if (state_q == ST_FILL) begin
            I_req  = 1'b1;
            I_addr = {tag_q, idx_q, cnt_q, 2'b00};
        end
    end

    assign I_write = 1'b0;
    assign I_in    = '0;
    assign I_type  = CACHE_WORD;

    // Next values for the request latch, beat counter, victim and flush flag
    always_comb begin
        idx_d        = idx_q;
        tag_d        = tag_q;
        woff_d       = woff_q;
        cnt_d        = cnt_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        if (accept) begin
            idx_d  = core_addr[OFF_BITS +: IDX_BITS];
            tag_d  = core_addr[31 -: TAG_BITS];
            woff_d = core_addr[2 +: WSEL_BITS];
        end
        if (miss_start) begin
            cnt_d    = '0;
            victim_d = victim_sel;
        end else if (beat_done) begin
            cnt_d = cnt_q + WSEL_BITS'(1);
        end
        if (flush_now) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            tag_q        <= '0;
            woff_q       <= '0;
            cnt_q        <= '0;
            victim_q     <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            woff_q       <= woff_d;
            cnt_q        <= cnt_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef L1CI_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // One count per LOOKUP outcome, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1c_inst_param.sv
// tb_l1c_inst_param: directed checks of l1c_inst_param with a fetch scoreboard.
// dut0 uses the default geometry; dut1 is direct-mapped with 8-word lines.
`timescale 1ns/1ps
module tb_l1c_inst_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr;
    logic        core_req0, core_req1;
    logic        flush;
    logic        I_wait;

    logic [31:0] core_out0, core_out1, I_addr0, I_addr1, I_in0, I_in1;
    logic [31:0] I_out0, I_out1;
    logic        core_wait0, core_wait1, I_req0, I_req1, I_write0, I_write1;
    logic [2:0]  I_type0, I_type1;
`ifdef L1CI_PERF_CNT_EN
    logic [31:0] hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1;
    int          exp_hit, exp_miss;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] log0[$];
    logic [31:0] log1[$];
    int          stall_req = 0;
    int          stall_used = 0;

    always #5 clk = ~clk;

    // Backing memory: word at byte address a holds 0x1000 + a/4
    assign I_out0 = 32'h1000 + (I_addr0 >> 2);
    assign I_out1 = 32'h1000 + (I_addr1 >> 2);

    l1c_inst_param dut0 (
        .clk(clk), .rst(rst), .core_addr(core_addr), .core_req(core_req0),
        .core_write(1'b0), .core_in(32'h0), .core_type(3'b010), .flush(flush),
        .I_out(I_out0), .I_wait(I_wait), .core_out(core_out0), .core_wait(core_wait0),
        .I_req(I_req0), .I_addr(I_addr0), .I_write(I_write0), .I_in(I_in0), .I_type(I_type0)
`ifdef L1CI_PERF_CNT_EN
        , .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0)
`endif
    );

    l1c_inst_param #(.SETS(64), .LINE_WORDS(8), .WAYS(1)) dut1 (
        .clk(clk), .rst(rst), .core_addr(core_addr), .core_req(core_req1),
        .core_write(1'b0), .core_in(32'h0), .core_type(3'b010), .flush(flush),
        .I_out(I_out1), .I_wait(1'b0), .core_out(core_out1), .core_wait(core_wait1),
        .I_req(I_req1), .I_addr(I_addr1), .I_write(I_write1), .I_in(I_in1), .I_type(I_type1)
`ifdef L1CI_PERF_CNT_EN
        , .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1)
`endif
    );

    // Stall the beat for word 2 of dut0's next fill for stall_req cycles once armed
    always @(negedge clk) begin
        if (stall_used < stall_req && I_req0 && I_addr0[3:2] == 2'd2) begin
            I_wait = 1'b1;
            stall_used++;
        end else begin
            I_wait = 1'b0;
        end
    end

    // Record completed fill beats
    always @(posedge clk) begin
        if (I_req0 && !I_wait) log0.push_back(I_addr0);
        if (I_req1) log1.push_back(I_addr1);
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string name);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // One fetch; flush_cyc: -1 none, 0 with the request, k>0 one cycle after the k-th edge
    task automatic fetch(input bit sel, input logic [31:0] addr, input int exp_lat,
                         input int flush_cyc, input string name);
        logic [31:0] expv, obs;
        int  lat;
        bit  got, quiet;
        exp_q.push_back(32'h1000 + (addr >> 2));
        @(negedge clk);
        core_addr = addr;
        if (sel) core_req1 = 1'b1; else core_req0 = 1'b1;
        if (flush_cyc == 0) flush = 1'b1;
        lat = 0; got = 1'b0; quiet = 1'b1; obs = '0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            flush = (lat == flush_cyc);
            if ((sel ? core_wait1 : core_wait0) == 1'b0) begin
                got = 1'b1;
                obs = sel ? core_out1 : core_out0;
            end else if ((sel ? core_out1 : core_out0) != 32'h0) begin
                quiet = 1'b0;
            end
        end
        expv = exp_q.pop_front();
        check(32'(got), 32'd1, {name, " served"});
        check(obs, expv, {name, " data"});
        check(lat, exp_lat, {name, " latency"});
        check(32'(quiet), 32'd1, {name, " out zero while waiting"});
        $display("fetch %s dut%0d addr=%h data=%h latency=%0d", name, sel, addr, obs, lat);
`ifdef L1CI_PERF_CNT_EN
        if (!sel) begin
            if (exp_lat == 1) exp_hit++;
            else begin exp_miss++; exp_hit++; end
        end
`endif
        @(negedge clk);
        core_req0 = 1'b0;
        core_req1 = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        int base, n208;
        rst = 1'b1; core_addr = '0; core_req0 = 1'b0; core_req1 = 1'b0; flush = 1'b0;
`ifdef L1CI_PERF_CNT_EN
        exp_hit = 0; exp_miss = 0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check(32'(core_wait0), 32'd1, "reset core_wait");
        check(core_out0, 32'h0, "reset core_out");
        check(32'(I_req0), 32'd0, "reset I_req");
        check(I_addr0, 32'h0, "reset I_addr");
        check(32'(core_wait1), 32'd1, "reset core_wait dut1");
`ifdef L1CI_PERF_CNT_EN
        check(hit_cnt0, 32'h0, "reset hit_cnt");
        check(miss_cnt0, 32'h0, "reset miss_cnt");
`endif

        // Direct-mapped, 8-word lines: 0x2000 shares set 0 with 0x0000
        fetch(1'b1, 32'h0000_0000, 10, -1, "dm cold");
        base = log1.size();
        fetch(1'b1, 32'h0000_2000, 10, -1, "dm conflict");
        check(log1.size() - base, 32'd8, "dm fill beats");
        check(log1[base], 32'h2000, "dm first beat addr");
        check(log1[base+7], 32'h201C, "dm last beat addr");
        fetch(1'b1, 32'h0000_0000, 10, -1, "dm evicted");

        // Cold miss then hit
        base = log0.size();
        fetch(1'b0, 32'h0000_0104, 6, -1, "cold miss");
        check(log0.size() - base, 32'd4, "cold fill beats");
        for (int i = 0; i < 4; i++) check(log0[base+i], 32'h100 + 32'(4*i), "cold beat addr");
        fetch(1'b0, 32'h0000_0108, 1, -1, "refetch hit");

        // Beat 2 stalled for 3 cycles
        stall_req = 3;
        base = log0.size();
        fetch(1'b0, 32'h0000_0204, 9, -1, "stalled fill");
        n208 = 0;
        for (int i = base; i < log0.size(); i++) if (log0[i] == 32'h208) n208++;
        check(log0.size() - base, 32'd4, "stalled fill beats");
        check(n208, 32'd1, "word2 written once");

        // Two-way conflict in set 0
        fetch(1'b0, 32'h0000_0000, 6, -1, "way A");
        fetch(1'b0, 32'h0000_0400, 6, -1, "way B");
        fetch(1'b0, 32'h0000_0000, 1, -1, "touch A");
        fetch(1'b0, 32'h0000_0800, 6, -1, "evict B");
        fetch(1'b0, 32'h0000_0000, 1, -1, "A kept");
        fetch(1'b0, 32'h0000_0400, 6, -1, "B evicted");

        // Flush during a fill, then flush together with a request
        fetch(1'b0, 32'h0000_0300, 6, 3, "flush mid-fill");
        fetch(1'b0, 32'h0000_0300, 7, -1, "after flush");
        fetch(1'b0, 32'h0000_0300, 1, -1, "hit before flush");
        fetch(1'b0, 32'h0000_0300, 7, 0, "flush with req");
`ifdef L1CI_PERF_CNT_EN
        check(hit_cnt0, 32'(exp_hit), "hit_cnt");
        check(miss_cnt0, 32'(exp_miss), "miss_cnt");
`endif

        // Asynchronous reset during beat 1 of a fill
        @(negedge clk);
        core_addr = 32'h0000_0500;
        core_req0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(32'(I_req0), 32'd1, "fill active before reset");
        check(I_addr0, 32'h504, "beat1 addr");
        #2 rst = 1'b1;
        #1;
        check(32'(I_req0), 32'd0, "I_req drops on reset");
        check(I_addr0, 32'h0, "I_addr on reset");
        check(32'(core_wait0), 32'd1, "core_wait on reset");
        @(negedge clk);
        core_req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`ifdef L1CI_PERF_CNT_EN
        check(hit_cnt0, 32'h0, "hit_cnt after reset");
        check(miss_cnt0, 32'h0, "miss_cnt after reset");
        exp_hit = 0; exp_miss = 0;
`endif
        fetch(1'b0, 32'h0000_0500, 6, -1, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
